dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported data memory. Accepts load/store requests from the pipeline LSU (port 0) and a secondary requester such as debug/DMA (port 1), grants one per transaction, drives the memory's chip-select, read/write enables and mask for exactly one access cycle, and returns read data or an error to the owning requester over a valid/ready response channel. Sits between the MEM stage and `data_memory`.

## Interface
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: data width; only 32 is supported.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid[1:0]` in 2: request valid, one bit per port.
- `req_ready[1:0]` out 2: request accepted, one bit per port.
- `req_we[1:0]` in 2: 1 = store, 0 = load.
- `req_addr0`, `req_addr1` in ADDR_W: byte address.
- `req_wdata0`, `req_wdata1` in 32: store data.
- `req_mask0`, `req_mask1` in 4: access type: byte signed 4'b0000, half signed 4'b0001, word 4'b1000, byte unsigned 4'b0010, half unsigned 4'b0100.
- `rsp_valid[1:0]` out 2: response valid, one bit per port; at most one bit set.
- `rsp_ready[1:0]` in 2: response consumed.
- `rsp_rdata` out 32: load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned address or illegal mask.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_mask` out 4: memory address, store data and mask.
- `mem_cs` out 1: chip select, active-low.
- `mem_rd_en` out 1: read enable, active-high.
- `mem_wr_en` out 1: write enable, active-low.
- `mem_rdata` in 32: combinational memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Arbitrate among `req_valid`.
  - `req_ready[g]` = 1 only for the granted port `g`; it is combinational from `req_valid` and the priority state.
  - On `req_valid[g] & req_ready[g]`, register addr, wdata, mask, we and owner `g`.
  - Legality check: half access needs `addr[0]` = 0; word access needs `addr[1:0]` = 0; mask must be one of the five legal encodings.
  - Illegal request: go to RESP with `err` = 1. No memory access occurs.
  - Legal request: go to ACCESS.
- **ACCESS** (exactly one cycle)
  - `mem_cs` = 0.
  - Load: `mem_rd_en` = 1, `mem_wr_en` = 1.
  - Store: `mem_rd_en` = 0, `mem_wr_en` = 0.
  - `mem_addr`, `mem_wdata` and `mem_mask` come from the registered request.
  - At the closing rising edge, capture `mem_rdata` into the response register for loads; capture 0 for stores.
  - Go to RESP.
- **RESP**
  - `rsp_valid[owner]` = 1; `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready[owner]`, go to IDLE.
  - No new request is accepted until the FSM is back in IDLE.
- **Outside ACCESS**: `mem_cs` = 1, `mem_rd_en` = 0, `mem_wr_en` = 1. `mem_addr`, `mem_wdata` and `mem_mask` hold their last values.
- **Arbitration**
  - Round-robin when configured: the port granted last has lowest priority next.
  - The priority pointer updates only on request acceptance, not on error-free or error completion.
- **Reset** (asserted at any time, including mid-ACCESS)
  - FSM returns to IDLE.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - `mem_cs` = 1, `mem_rd_en` = 0, `mem_wr_en` = 1, `mem_addr` = 0, `mem_wdata` = 0, `mem_mask` = 4'b1000.
  - Priority pointer resets to favour port 0.
  - A store interrupted by reset before the memory's falling edge is lost; this is acceptable.

## Timing
- Legal request accepted at edge E0: ACCESS runs E0→E1, `rsp_valid` rises after E1.
  - Minimum request-to-response latency: 2 cycles.
  - Back-to-back throughput: one transaction per 3 cycles (accept, access, response with `rsp_ready` = 1, then IDLE).
- Illegal request: `rsp_valid` rises after E0, 1 cycle.
- Store data is written by the memory at the falling edge inside the ACCESS cycle.
- A requester must hold `req_*` stable while `req_valid` = 1 and `req_ready` = 0.
- Simultaneous valid on both ports: only one `req_ready` is asserted in a cycle. The loser keeps waiting with no timeout.
- `rsp_ready` held low indefinitely stalls the block in RESP. Neither port is granted while stalled.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration as above.
- `DMEM_ARB_RR_EN` undefined:
  - Fixed priority; port 0 (LSU) always wins.
  - The priority pointer flop is not built.
  - Port 1 can starve; this is permitted.

## Structure
- Package `dmem_pkg`:
  - Mask encoding constants (`MASK_BS`, `MASK_HS`, `MASK_W`, `MASK_BU`, `MASK_HU`).
  - FSM state enum `dmem_arb_state_e`.
  - Legality function `dmem_access_legal(addr, mask)`.
- Sub-module `dmem_rr_grant`: 2-way arbiter producing a one-hot grant from `req_valid`, the pointer, and an update enable. In fixed mode it reduces to port 0 priority.
- Everything else lives in a single `dmem_arbiter` top.

## Test plan
- Port 0 word store addr 0x10 data 0xDEADBEEF, then word load 0x10 → store response `err` = 0, `rdata` = 0; load `rdata` = 0xDEADBEEF, `rsp_valid` exactly 2 cycles after acceptance.
- Byte-signed load at 0x11 after storing 0x00008000 to 0x10 → `rdata` = 0xFFFFFF80; byte-unsigned load at 0x11 → 0x00000080.
- Half load at 0x13 → `rsp_err` = 1 and `rdata` = 0 after 1 cycle; `mem_cs` stays 1 throughout.
- Both ports valid continuously with `rsp_ready` = 1:
  - With `DMEM_ARB_RR_EN`, grants alternate 0,1,0,1.
  - Without it, port 0 receives every grant.
- `rsp_ready` held 0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` stable; `req_ready` = 0 on both ports.
- Reset asserted during ACCESS → asynchronously `mem_cs` = 1, `rsp_valid` = 0, FSM in IDLE; the next request completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-type mask encodings,
// the arbiter FSM state type and the alignment/encoding legality check.
package dmem_pkg;

    localparam logic [3:0] MASK_BS = 4'b0000;  // byte, sign-extended
    localparam logic [3:0] MASK_HS = 4'b0001;  // half, sign-extended
    localparam logic [3:0] MASK_W  = 4'b1000;  // word
    localparam logic [3:0] MASK_BU = 4'b0010;  // byte, zero-extended
    localparam logic [3:0] MASK_HU = 4'b0100;  // half, zero-extended

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_arb_state_e;

    // A request is legal when its mask is one of the five encodings and the
    // byte address is naturally aligned for the access size.
    function automatic logic dmem_access_legal(input logic [1:0] addr, input logic [3:0] mask);
        logic legal;
        case (mask)
            MASK_BS, MASK_BU: legal = 1'b1;
            MASK_HS, MASK_HU: legal = ~addr[0];
            MASK_W:           legal = (addr == 2'b00);
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_rr_grant.sv
// Two-way grant generator for dmem_arbiter.
// DMEM_ARB_RR_EN defined   : round-robin, the port granted last loses a tie.
// DMEM_ARB_RR_EN undefined : fixed priority, port 0 always wins a tie.
module dmem_rr_grant (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
    // 1: port 1 was granted last, so port 0 wins the next tie.
    logic last_q;

    // Remember which port won, but only when a request is actually accepted.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block evaluation order.
        if (!reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= grant[1];
        end
    end

    // One-hot grant: a lone requester always wins, a tie goes against last_q.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end
`else
    // Clock, reset and update have no consumer without a priority pointer.
    logic unused_sink;
    assign unused_sink = ^{clk, reset, update};

    // Port 0 always takes precedence over port 1.
    always_comb begin
        grant = {req[1] & ~req[0], req[0]};
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the single-ported data
// memory. Port 0 is the pipeline LSU, port 1 a secondary requester.
// Optional feature: DMEM_ARB_RR_EN selects round-robin instead of fixed
// port-0 priority (see dmem_rr_grant).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    input  logic [3:0]        req_mask0,
    input  logic [3:0]        req_mask1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_mask,
    output logic              mem_cs,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_arb_state_e   state_q, state_d;
    logic [1:0]        grant;
    logic [1:0]        accept;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_mask;
    logic              sel_we;
    logic              sel_legal;
    logic              owner_q;
    logic              we_q;

    dmem_rr_grant u_grant (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .update (|accept),
        .grant  (grant)
    );

    assign accept    = req_valid & req_ready;
    assign sel       = grant[1];
    assign sel_addr  = sel ? req_addr1  : req_addr0;
    assign sel_wdata = sel ? req_wdata1 : req_wdata0;
    assign sel_mask  = sel ? req_mask1  : req_mask0;
    assign sel_we    = req_we[sel];
    assign sel_legal = dmem_access_legal(sel_addr[1:0], sel_mask);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the handshake and memory strobes decoded from the state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would infer a latch.
        state_d   = state_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        mem_cs    = 1'b1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b1;
        case (state_q)
            IDLE: begin
                // Held off while reset is low so nothing looks accepted.
                req_ready = reset ? grant : 2'b00;
                if (reset && |(req_valid & grant)) begin
                    state_d = sel_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_cs    = 1'b0;
                mem_rd_en = ~we_q;
                mem_wr_en = ~we_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture on acceptance, read-data capture at the end of ACCESS.
    // The memory-side registers load only for legal requests so they hold
    // their last access across errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= MASK_W;
        end else if (|accept) begin
            owner_q   <= sel;
            we_q      <= sel_we;
            rsp_err   <= ~sel_legal;
            rsp_rdata <= '0;
            if (sel_legal) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_mask  <= sel_mask;
            end
        end else if (state_q == ACCESS) begin
            rsp_rdata <= we_q ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory and a
// transaction-level reference model compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_we;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [3:0]  req_mask0, req_mask1;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic        mem_cs, mem_rd_en, mem_wr_en;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_mask0(req_mask0), .req_mask1(req_mask1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_cs(mem_cs), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural data memory (device) ----------------
    logic [7:0]  dev_mem [256];
    logic [31:0] dev_v;

    function automatic int nbytes(input logic [3:0] m);
        if (m == 4'b1000) return 4;
        if (m == 4'b0001 || m == 4'b0100) return 2;
        return 1;
    endfunction

    always @(negedge clk) begin
        if (!mem_cs && !mem_wr_en) begin
            for (int i = 0; i < nbytes(mem_mask); i++)
                dev_mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        dev_v = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(mem_mask)) dev_v[8*i +: 8] = dev_mem[8'(mem_addr[7:0] + 8'(i))];
        if (mem_mask == 4'b0000)      mem_rdata = {{24{dev_v[7]}}, dev_v[7:0]};
        else if (mem_mask == 4'b0001) mem_rdata = {{16{dev_v[15]}}, dev_v[15:0]};
        else                          mem_rdata = dev_v;
    end

    // ---------------- reference model ----------------
    logic [7:0] mem_ref [256];

    function automatic bit ref_legal(input logic [31:0] a, input logic [3:0] m);
        if (!(m inside {4'b0000, 4'b0001, 4'b1000, 4'b0010, 4'b0100})) return 0;
        if ((m == 4'b0001 || m == 4'b0100) && a[0]) return 0;
        if (m == 4'b1000 && a[1:0] != 2'b00) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [3:0] m);
        logic [31:0] w;
        w = {mem_ref[8'(a + 8'd3)], mem_ref[8'(a + 8'd2)], mem_ref[8'(a + 8'd1)], mem_ref[a]};
        case (m)
            4'b1000: return w;
            4'b0100: return {16'h0, w[15:0]};
            4'b0001: return {{16{w[15]}}, w[15:0]};
            4'b0010: return {24'h0, w[7:0]};
            default: return {{24{w[7]}}, w[7:0]};
        endcase
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        mem_ref[a] = d[7:0];
        if (m == 4'b1000 || m == 4'b0001 || m == 4'b0100) mem_ref[8'(a + 8'd1)] = d[15:8];
        if (m == 4'b1000) begin
            mem_ref[8'(a + 8'd2)] = d[23:16];
            mem_ref[8'(a + 8'd3)] = d[31:24];
        end
    endtask

    // Model: an accepted transaction at cycle k owns the memory in cycle k+1
    // (legal only) and responds from cycle k+2 (legal) or k+1 (illegal)
    // until its owner takes it.
    int          cyc = 0;
    bit          m_busy, m_legal, m_we, m_err;
    int          m_owner, m_acc_cyc, m_rsp_from, m_last;
    logic [31:0] m_rdata, m_maddr, m_mwdata;
    logic [3:0]  m_mmask;

    always @(negedge clk) begin
        logic [1:0]  exp_ready;
        bit          in_acc, resp;
        logic [31:0] a, d;
        logic [3:0]  m;
        if (!reset) begin
            m_busy  = 0;
            m_last  = 1;
            m_maddr = 0;
            m_mwdata = 0;
            m_mmask = 4'b1000;
        end else begin
            in_acc = m_busy && m_legal && (cyc == m_acc_cyc + 1);
            resp   = m_busy && (cyc >= m_rsp_from);
            exp_ready = 2'b00;
            if (!m_busy) begin
                if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
                    exp_ready = (m_last == 0) ? 2'b10 : 2'b01;
`else
                    exp_ready = 2'b01;
`endif
                end else begin
                    exp_ready = req_valid;
                end
            end
            check("req_ready", {30'h0, req_ready}, {30'h0, exp_ready});
            check("rsp_valid", {30'h0, rsp_valid}, resp ? (m_owner == 1 ? 32'd2 : 32'd1) : 32'd0);
            if (resp) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
            end
            check("mem_cs", {31'h0, mem_cs}, {31'h0, !in_acc});
            check("mem_rd_en", {31'h0, mem_rd_en}, {31'h0, in_acc && !m_we});
            check("mem_wr_en", {31'h0, mem_wr_en}, {31'h0, !(in_acc && m_we)});
            check("mem_addr", mem_addr, m_maddr);
            check("mem_wdata", mem_wdata, m_mwdata);
            check("mem_mask", {28'h0, mem_mask}, {28'h0, m_mmask});
            if (exp_ready != 2'b00) begin
                m_owner = exp_ready[1] ? 1 : 0;
                a = m_owner ? req_addr1 : req_addr0;
                d = m_owner ? req_wdata1 : req_wdata0;
                m = m_owner ? req_mask1 : req_mask0;
                m_we    = req_we[m_owner];
                m_legal = ref_legal(a, m);
                m_err   = !m_legal;
                m_rdata = 0;
                if (m_legal) begin
                    m_maddr = a; m_mwdata = d; m_mmask = m;
                    if (m_we) ref_store(a[7:0], m, d);
                    else      m_rdata = ref_load(a[7:0], m);
                end
                m_acc_cyc  = cyc;
                m_rsp_from = cyc + (m_legal ? 2 : 1);
                m_last     = m_owner;
                m_busy     = 1;
            end else if (resp && rsp_ready[m_owner]) begin
                m_busy = 0;
            end
        end
        cyc++;
    end

    // Grant order as observed on the DUT pins.
    bit log_en = 0;
    int dut_grants[$];
    always @(negedge clk) begin
        if (log_en && reset && |(req_valid & req_ready)) dut_grants.push_back(req_ready[1] ? 1 : 0);
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
        req_we[p] = we;
        if (p == 0) begin req_addr0 = a; req_wdata0 = d; req_mask0 = m; end
        else        begin req_addr1 = a; req_wdata1 = d; req_mask1 = m; end
    endtask

    task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output logic er,
                       output int lat, output bit cs_low);
        int n;
        set_req(p, we, a, d, m);
        req_valid[p] = 1'b1;
        rsp_ready = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[p] && n < 50);
        if (!req_ready[p]) check("accept_timeout", {31'h0, req_ready[p]}, 32'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        lat = 0; cs_low = 0;
        do begin
            @(negedge clk); lat++;
            if (!mem_cs) cs_low = 1;
        end while (!rsp_valid[p] && lat < 50);
        if (!rsp_valid[p]) check("rsp_timeout", {31'h0, rsp_valid[p]}, 32'd1);
        rd = rsp_rdata; er = rsp_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          csl;
    logic [1:0]  acc;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin dev_mem[i] = 8'h0; mem_ref[i] = 8'h0; end
        reset = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; rsp_ready = 2'b00;
        req_addr0 = 0; req_addr1 = 0; req_wdata0 = 0; req_wdata1 = 0;
        req_mask0 = 4'b1000; req_mask1 = 4'b1000;
        #12;
        check("rst_req_ready", {30'h0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'h0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        check("rst_mem_cs", {31'h0, mem_cs}, 32'd1);
        check("rst_mem_rd_en", {31'h0, mem_rd_en}, 32'd0);
        check("rst_mem_wr_en", {31'h0, mem_wr_en}, 32'd1);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_mask", {28'h0, mem_mask}, 32'h8);
        req_valid = 2'b00;
        @(posedge clk); #2 reset = 1'b1;

        // Both ports continuously valid.
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h20, 32'h0, 4'b1000);
        set_req(1, 1'b0, 32'h24, 32'h0, 4'b1000);
        rsp_ready = 2'b11;
        log_en = 1;
        req_valid = 2'b11;
        repeat (20) @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 log_en = 0;
        if (dut_grants.size() < 4) begin
            check("grant_count", dut_grants.size(), 32'd4);
        end else begin
            for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
                check("grant_order", dut_grants[i], i % 2);
`else
                check("grant_order", dut_grants[i], 32'd0);
`endif
            end
        end

        // Store then load a word.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1000, rd, er, lat, csl);
        check("st_err", {31'h0, er}, 32'd0);
        check("st_rdata", rd, 32'd0);
        check("st_lat", lat, 32'd2);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b1000, rd, er, lat, csl);
        check("ld_word", rd, 32'hDEADBEEF);
        check("ld_lat", lat, 32'd2);

        // Signed and unsigned byte loads.
        txn(0, 1'b1, 32'h10, 32'h00008000, 4'b1000, rd, er, lat, csl);
        txn(0, 1'b0, 32'h11, 32'h0, 4'b0000, rd, er, lat, csl);
        check("ld_bs", rd, 32'hFFFFFF80);
        txn(0, 1'b0, 32'h11, 32'h0, 4'b0010, rd, er, lat, csl);
        check("ld_bu", rd, 32'h00000080);

        // Misaligned half load.
        txn(0, 1'b0, 32'h13, 32'h0, 4'b0001, rd, er, lat, csl);
        check("mis_err", {31'h0, er}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_lat", lat, 32'd1);
        check("mis_cs_low", {31'h0, csl}, 32'd0);

        // Response stall with port 1 waiting.
        set_req(0, 1'b0, 32'h10, 32'h0, 4'b1000);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!req_ready[0] && lat < 50);
        check("stall_accept", {31'h0, req_ready[0]}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        set_req(1, 1'b0, 32'h14, 32'h0, 4'b1000);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid[0] && lat < 50);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", {30'h0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'h00008000);
            check("stall_req_ready", {30'h0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!req_ready[1] && lat < 50);
        check("p1_accept", {31'h0, req_ready[1]}, 32'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid[1] && lat < 50);
        check("p1_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of ACCESS.
        set_req(0, 1'b0, 32'h10, 32'h0, 4'b1000);
        req_valid = 2'b01;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!req_ready[0] && lat < 50);
        @(posedge clk); #1 req_valid = 2'b00;
        #1;
        check("pre_rst_cs", {31'h0, mem_cs}, 32'd0);
        reset = 1'b0;
        #1;
        check("arst_cs", {31'h0, mem_cs}, 32'd1);
        check("arst_rd_en", {31'h0, mem_rd_en}, 32'd0);
        check("arst_rsp_valid", {30'h0, rsp_valid}, 32'd0);
        check("arst_req_ready", {30'h0, req_ready}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_mask", {28'h0, mem_mask}, 32'h8);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h10, 32'h0, 4'b1000, rd, er, lat, csl);
        check("post_rst_ld", rd, 32'h00008000);
        check("post_rst_lat", lat, 32'd2);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] || acc[p]) begin
                    logic [31:0] a;
                    logic [3:0]  m;
                    int          r;
                    r = $urandom_range(0, 6);
                    case (r)
                        0: m = 4'b0000; 1: m = 4'b0001; 2: m = 4'b1000;
                        3: m = 4'b0010; 4: m = 4'b0100; 5: m = 4'b1111;
                        default: m = 4'b0011;
                    endcase
                    a = 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                    set_req(p, 1'($urandom_range(0, 1)), a, $urandom, m);
                    req_valid[p] = ($urandom_range(0, 2) != 0);
                end
            end
            rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
